// File: rtl/flash_pin_arbiter_if.sv
// rtl/flash_pin_arbiter_if.sv - requester, flash pin and status signals shared by the QSPI pin arbiter
interface flash_pin_arbiter_if;
    logic       m0_req;
    logic       m0_gnt;
    logic       m0_csb;
    logic       m0_clk;
    logic [3:0] m0_io_do;
    logic [3:0] m0_io_oeb;
    logic [3:0] m0_io_di;

    logic       m1_req;
    logic       m1_gnt;
    logic       m1_csb;
    logic       m1_clk;
    logic [3:0] m1_io_do;
    logic [3:0] m1_io_oeb;
    logic [3:0] m1_io_di;

    logic       flash_csb;
    logic       flash_clk;
    logic [3:0] flash_io_do;
    logic [3:0] flash_io_oeb;
    logic [3:0] flash_io_di;

    logic       busy;
    logic       owner;

    // Requesters and the io_buf side drive these; the arbiter observes them
    modport master (
        output m0_req, m0_csb, m0_clk, m0_io_do, m0_io_oeb,
        output m1_req, m1_csb, m1_clk, m1_io_do, m1_io_oeb,
        output flash_io_di,
        input  m0_gnt, m0_io_di, m1_gnt, m1_io_di,
        input  flash_csb, flash_clk, flash_io_do, flash_io_oeb,
        input  busy, owner
    );

    // The arbiter's view
    modport slave (
        input  m0_req, m0_csb, m0_clk, m0_io_do, m0_io_oeb,
        input  m1_req, m1_csb, m1_clk, m1_io_do, m1_io_oeb,
        input  flash_io_di,
        output m0_gnt, m0_io_di, m1_gnt, m1_io_di,
        output flash_csb, flash_clk, flash_io_do, flash_io_oeb,
        output busy, owner
    );
endinterface

// File: rtl/flash_pin_arbiter.sv
// rtl/flash_pin_arbiter.sv - round-robin owner of the QSPI flash pins with a parked guard gap between owners
module flash_pin_arbiter #(
    parameter int GUARD_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic                 core_clk,
    input  logic                 core_rst,
    flash_pin_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               m0_gnt_q, m0_gnt_d;
    logic               m1_gnt_q, m1_gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State, grants, owner and guard counter; reset clears grants so the pins park without a clock
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b1;
            m0_gnt_q <= 1'b0;
            m1_gnt_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            m0_gnt_q <= m0_gnt_d;
            m1_gnt_q <= m1_gnt_d;
            cnt_q    <= cnt_d;
        end
    end

    // Arbitration: owners release only with req low and csb high; the guard then counts down to IDLE
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    // Round-robin: the side that did not own last time wins the tie
                    state_d = owner_q ? GNT0 : GNT1;
                    owner_d = ~owner_q;
                end else if (bus.m0_req) begin
                    state_d = GNT0;
                    owner_d = 1'b0;
                end else if (bus.m1_req) begin
                    state_d = GNT1;
                    owner_d = 1'b1;
                end
            end
            GNT0: begin
                if (!bus.m0_req && bus.m0_csb) begin
                    state_d = GUARD;
                    cnt_d   = CNT_W'(GUARD_CYCLES - 1);
                end
            end
            GNT1: begin
                if (!bus.m1_req && bus.m1_csb) begin
                    state_d = GUARD;
                    cnt_d   = CNT_W'(GUARD_CYCLES - 1);
                end
            end
            GUARD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        m0_gnt_d = (state_d == GNT0);
        m1_gnt_d = (state_d == GNT1);
    end

    // Pin mux: the granted requester drives the pins directly, otherwise they sit parked
    always_comb begin
        bus.flash_csb    = 1'b1;
        bus.flash_clk    = 1'b0;
        bus.flash_io_do  = 4'h0;
        bus.flash_io_oeb = 4'hF;
        bus.m0_io_di     = 4'h0;
        bus.m1_io_di     = 4'h0;
        if (m0_gnt_q) begin
            bus.flash_csb    = bus.m0_csb;
            bus.flash_clk    = bus.m0_clk;
            bus.flash_io_do  = bus.m0_io_do;
            bus.flash_io_oeb = bus.m0_io_oeb;
            bus.m0_io_di     = bus.flash_io_di;
        end else if (m1_gnt_q) begin
            bus.flash_csb    = bus.m1_csb;
            bus.flash_clk    = bus.m1_clk;
            bus.flash_io_do  = bus.m1_io_do;
            bus.flash_io_oeb = bus.m1_io_oeb;
            bus.m1_io_di     = bus.flash_io_di;
        end
    end

    assign bus.m0_gnt = m0_gnt_q;
    assign bus.m1_gnt = m1_gnt_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: doc/flash_pin_arbiter.md
Name: flash_pin_arbiter

Overview:
Shares the single set of QSPI flash pins (csb, clk, io[3:0] do/oeb/di) between two requesters.
- Requester 0 is the management core flash controller.
- Requester 1 is an external programming/debug passthrough.

It sits between the requesters and the flash io_buf instances. It never cuts an owner off mid-transaction (csb low). Between owners it parks the pins in a safe idle state for a guard interval.

Parameters:
GUARD_CYCLES, 4, cycles of parked pins between ownership changes (legal range 1..255)
CNT_W, 8, width of guard counter (must hold GUARD_CYCLES)

Ports:
core_clk  input  1  block clock
core_rst  input  1  reset, asynchronous, active-high
m0_req  input  1  requester 0 wants the flash pins
m0_gnt  output  1  requester 0 owns the pins
m0_csb  input  1  requester 0 chip select (active low)
m0_clk  input  1  requester 0 SPI clock
m0_io_do  input  4  requester 0 data out
m0_io_oeb  input  4  requester 0 output enables (1 = input)
m0_io_di  output  4  flash data in returned to requester 0
m1_req, m1_gnt, m1_csb, m1_clk, m1_io_do, m1_io_oeb, m1_io_di  same as m0_*, for requester 1
flash_csb  output  1  to flash pin
flash_clk  output  1  to flash pin
flash_io_do  output  4  to io_buf din_i
flash_io_oeb  output  4  to io_buf in_not_out_i
flash_io_di  input  4  from io_buf dout_o
busy  output  1  any requester granted or guard active
owner  output  1  index of last/current grantee

Behaviour:
Clocking and reset
- Single clock core_clk. Reset core_rst is asynchronous, active-high.
- State after reset:
  - state=IDLE, m0_gnt=0, m1_gnt=0, busy=0
  - owner=1, so requester 0 wins the first contention
  - flash_csb=1, flash_clk=0, flash_io_do=4'h0, flash_io_oeb=4'hF
  - m0_io_di=m1_io_di=4'h0

States: IDLE, GNT0, GNT1, GUARD. State, gnt, owner and guard counter are registers. The pin mux is combinational from the registered state.

IDLE
- Pins parked (csb=1, clk=0, do=0, oeb=F).
- m0_req only -> GNT0. m1_req only -> GNT1.
- Both requesting -> grant the requester != owner (round-robin).
- Grant is visible the cycle after req is sampled high: 1-cycle latency.
- owner updates on the same edge as the grant.

GNTx
- mx_gnt=1, busy=1.
- flash_csb/clk/io_do/io_oeb follow mx_* combinationally.
- mx_io_di = flash_io_di. The other requester's di = 4'h0.
- Exit only when mx_req==0 AND mx_csb==1 in the same cycle. Then go to GUARD: gnt drops on that edge, and the guard counter loads GUARD_CYCLES-1.
- If mx_req drops while mx_csb==0, the grant is held until csb rises. No preemption, no timeout.
- A request from the other side during GNTx is ignored until the return to IDLE.

GUARD
- Pins parked, both gnt=0, busy=1.
- Counter decrements each cycle; at 0 go to IDLE.
- GUARD lasts exactly GUARD_CYCLES cycles. Minimum pin-park gap between two grants is GUARD_CYCLES+1 cycles (guard plus the IDLE arbitration cycle).

General rules
- A req held high continuously across its own release re-competes in IDLE under round-robin. A lone requester is re-granted.
- Reset asserted mid-transaction: pins park immediately (asynchronous) and grants clear. The requester must restart its flash command.
- busy = (state != IDLE).

Test Plan:
1. Reset release, no requests -> flash_csb=1, flash_clk=0, flash_io_oeb=4'hF, busy=0, both gnt=0 held for 20 cycles.
2. m0_req=1 at cycle 0 -> m0_gnt=1 at cycle 1.
   - Drive m0_csb=0, m0_io_oeb=4'hE, m0_io_do=4'h1 -> flash pins mirror them the same cycle.
   - flash_io_di=4'hA -> m0_io_di=4'hA, m1_io_di=4'h0.
3. m0 owns with m0_csb=0; drop m0_req at cycle 10 and raise m0_csb at cycle 15 -> m0_gnt stays 1 through cycle 15 and drops at cycle 16; pins parked cycles 16..19 (GUARD_CYCLES=4).
4. m0_req and m1_req both held high from reset, each releasing 8 cycles after its grant with csb high -> grant order m0, m1, m0, m1; grants separated by exactly 5 parked cycles.
5. m1 owns; m0_req rises mid-grant -> m0_gnt stays 0 until m1 releases; m0_gnt rises exactly GUARD_CYCLES+1 cycles after m1_gnt falls.
6. core_rst asserted while m1_gnt=1 and m1_csb=0 -> flash_csb=1, flash_io_oeb=4'hF, m1_gnt=0 immediately without a clock edge. After release, m1 is re-granted 1 cycle after its req is sampled.
